pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
// - Parametrised program-counter generator; successor to the single enable-gated PC register.
// - Sits at the IF stage head and offers fetch addresses over a valid/ready handshake.
// - Sequential increment, prioritised trap/branch redirects, misaligned-target detection,
//   a boot delay after reset, and a debug halt.
// PARAMETERS
// - ADDR_WIDTH    32            PC width in bits (from my_pkg)
// - RESET_VECTOR  32'h0000_0000 PC value loaded at reset
// - INST_BYTES    4             increment step; power of two (2 or 4)
// - BOOT_CYCLES   2             cycles in BOOT after reset release before the first valid PC (>=1)
// PORTS
// - clk          in   1           core clock
// - rst_n        in   1           asynchronous, active-low reset
// - pc_o         out  ADDR_WIDTH  fetch address offered to IF
// - pc_valid_o   out  1           pc_o is a valid fetch request
// - pc_ready_i   in   1           IF accepts pc_o this cycle
// - br_valid_i   in   1           EX branch/jump redirect request
// - br_target_i  in   ADDR_WIDTH  branch/jump target
// - trap_valid_i in   1           trap redirect request
// - trap_vec_i   in   ADDR_WIDTH  trap handler address
// - halt_req_i   in   1           debug halt request, level-sensitive
// - halted_o     out  1           block is in HALT
// - misalign_o   out  1           one-cycle pulse: rejected misaligned branch target
// BEHAVIOUR
// Reset
// - Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, halted_o=0, misalign_o=0,
//   state=BOOT, boot counter=0.
// - A reset assertion mid-operation immediately restores these values. Any pending redirect is lost.
// FSM (BOOT, RUN, HALT), pc_state_e
// - BOOT: the boot counter increments each cycle. After BOOT_CYCLES cycles the state goes to RUN.
//   pc_valid_o=0 throughout BOOT.
// - RUN: pc_valid_o=1. If halt_req_i=1, the next state is HALT.
// - HALT: pc_valid_o=0, halted_o=1. When halt_req_i=0, the next state is RUN.
// PC update (registered, one-cycle latency)
// - Priority: trap_valid_i > br_valid_i > handshake (pc_valid_o & pc_ready_i) > hold.
// - Trap: pc_o <= trap_vec_i with the low log2(INST_BYTES) bits forced to 0.
// - Branch: if the low log2(INST_BYTES) bits of br_target_i are 0, then pc_o <= br_target_i.
//   Otherwise pc_o holds, misalign_o=1 next cycle, and the branch is dropped.
// - Handshake: pc_o <= pc_o + INST_BYTES, wrapping modulo 2^ADDR_WIDTH
//   (e.g. 32'hFFFF_FFFC -> 32'h0).
// - Trap and branch in the same cycle: the trap wins and misalign_o is not raised.
// - Redirects take effect in every state, including BOOT and HALT.
//   A redirect in HALT sets the resume PC.
// - A redirect coinciding with a handshake: the redirect wins. The accepted pc_o is
//   not re-offered (IF flushes it).
// - Handshake rule: while pc_valid_o=1 and pc_ready_i=0, pc_o stays stable unless a redirect occurs.
//   A redirect is the only permitted change of an unaccepted request.
// - Halt and handshake in the same cycle: the handshake completes (PC increments), then HALT.
// - misalign_o is registered and cleared on the following cycle.
// STRUCTURE
// - my_pkg: ADDR_WIDTH, DEFAULT_RESET_VECTOR, typedef enum logic[1:0] pc_state_e {BOOT,RUN,HALT}.
// - One natural sub-module: pc_redirect_mux.
//   - Combinational priority select plus alignment check.
//   - Outputs: next_pc, take, misalign.
// - Top level holds the FSM, the boot counter, and the pc/flag registers.
// TESTING
// - Reset, BOOT_CYCLES=2, pc_ready_i=1
//   -> pc_valid_o=0 for 2 cycles, then pc_o=0x0,0x4,0x8.
// - pc_ready_i=0 for 3 cycles at pc_o=0x10
//   -> pc_o holds 0x10, then 0x14 one cycle after ready rises.
// - br_valid_i=1, br_target_i=0x200, with a coincident handshake at 0x10
//   -> next pc_o=0x200.
//   br_target_i=0x202 -> pc_o held, misalign_o pulses 1 cycle.
// - trap_valid_i=1, trap_vec_i=0x103, with br_valid_i=1, br_target_i=0x200 in the same cycle
//   -> pc_o=0x100, misalign_o=0.
// - halt_req_i=1 at pc_o=0x40
//   -> halted_o=1, pc_valid_o=0.
//   Branch to 0x80 while halted, then halt_req_i=0 -> pc_valid_o=1 with pc_o=0x80.
// - pc_o=32'hFFFF_FFFC with a handshake -> pc_o=0x0.
//   rst_n low mid-stream -> pc_o=RESET_VECTOR, pc_valid_o=0 immediately.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and defaults for the program-counter generator.
package my_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// Next-PC selection: trap > branch > sequential handshake > hold.
// A branch to a misaligned target is dropped and flagged; the PC holds.
module pc_redirect_mux
   import my_pkg::*;
#(
   parameter int ADDR_WIDTH = my_pkg::ADDR_WIDTH,
   parameter int INST_BYTES = 4
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  handshake,
   input  logic                  trap_valid,
   input  logic [ADDR_WIDTH-1:0] trap_vec,
   input  logic                  br_valid,
   input  logic [ADDR_WIDTH-1:0] br_target,
   output logic [ADDR_WIDTH-1:0] next_pc,
   output logic                  take,
   output logic                  misalign
);

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);

   // Priority select of the next PC with the branch alignment check
   always_comb begin
      next_pc  = pc;
      take     = 1'b0;
      misalign = 1'b0;
      if (trap_valid) begin
         next_pc = trap_vec & ~ALIGN_MASK;
         take    = 1'b1;
      end else if (br_valid) begin
         if ((br_target & ALIGN_MASK) == '0) begin
            next_pc = br_target;
            take    = 1'b1;
         end else begin
            misalign = 1'b1;
         end
      end else if (handshake) begin
         next_pc = pc + STEP;
         take    = 1'b1;
      end
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator at the head of IF: boot delay, run/halt
// sequencing, and the PC register offered over a valid/ready handshake.
//
// state | meaning
// BOOT  | post-reset delay, no fetch offered, boot counter running
// RUN   | pc_o offered to IF, advances on accept
// HALT  | debug halt, no fetch offered, redirects still set the resume PC
module pc_gen_unit
   import my_pkg::*;
#(
   parameter int                             ADDR_WIDTH   = my_pkg::ADDR_WIDTH,
   parameter logic [my_pkg::ADDR_WIDTH-1:0]  RESET_VECTOR = my_pkg::DEFAULT_RESET_VECTOR,
   parameter int                             INST_BYTES   = 4,
   parameter int                             BOOT_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  pc_valid_o,
   input  logic                  pc_ready_i,
   input  logic                  br_valid_i,
   input  logic [ADDR_WIDTH-1:0] br_target_i,
   input  logic                  trap_valid_i,
   input  logic [ADDR_WIDTH-1:0] trap_vec_i,
   input  logic                  halt_req_i,
   output logic                  halted_o,
   output logic                  misalign_o
);

   localparam int              CNT_W     = $clog2(BOOT_CYCLES + 1);
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

   pc_state_e             state;
   logic [CNT_W-1:0]      boot_cnt;
   logic [ADDR_WIDTH-1:0] next_pc;
   logic                  take;
   logic                  misalign;

   pc_redirect_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_BYTES (INST_BYTES)
   ) u_redirect_mux (
      .pc         (pc_o),
      .handshake  (pc_valid_o & pc_ready_i),
      .trap_valid (trap_valid_i),
      .trap_vec   (trap_vec_i),
      .br_valid   (br_valid_i),
      .br_target  (br_target_i),
      .next_pc    (next_pc),
      .take       (take),
      .misalign   (misalign)
   );

   // Sequencing FSM plus PC and flag registers; outputs registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         boot_cnt   <= '0;
         pc_o       <= RESET_VECTOR;
         pc_valid_o <= 1'b0;
         halted_o   <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         misalign_o <= misalign;
         if (take) begin
            pc_o <= next_pc;
         end
         case (state)
            BOOT: begin
               boot_cnt <= boot_cnt + CNT_W'(1);
               if (boot_cnt == BOOT_LAST) begin
                  state      <= RUN;
                  pc_valid_o <= 1'b1;
               end
            end
            RUN: begin
               if (halt_req_i) begin
                  state      <= HALT;
                  pc_valid_o <= 1'b0;
                  halted_o   <= 1'b1;
               end
            end
            HALT: begin
               if (!halt_req_i) begin
                  state      <= RUN;
                  pc_valid_o <= 1'b1;
                  halted_o   <= 1'b0;
               end
            end
            default: begin
               state      <= BOOT;
               boot_cnt   <= '0;
               pc_valid_o <= 1'b0;
               halted_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed and randomized checks of pc_gen_unit against a cycle-level
// behavioural model.
module tb_pc_gen_unit;

   localparam int          AW     = 32;
   localparam logic [31:0] RV     = 32'h0000_0000;
   localparam int          IB     = 4;
   localparam int          BOOT_N = 2;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] pc_o;
   logic          pc_valid_o;
   logic          pc_ready_i;
   logic          br_valid_i;
   logic [AW-1:0] br_target_i;
   logic          trap_valid_i;
   logic [AW-1:0] trap_vec_i;
   logic          halt_req_i;
   logic          halted_o;
   logic          misalign_o;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_halted;
   logic        m_mis;
   int          m_boot_left;

   pc_gen_unit #(
      .ADDR_WIDTH   (AW),
      .RESET_VECTOR (RV),
      .INST_BYTES   (IB),
      .BOOT_CYCLES  (BOOT_N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_o         (pc_o),
      .pc_valid_o   (pc_valid_o),
      .pc_ready_i   (pc_ready_i),
      .br_valid_i   (br_valid_i),
      .br_target_i  (br_target_i),
      .trap_valid_i (trap_valid_i),
      .trap_vec_i   (trap_vec_i),
      .halt_req_i   (halt_req_i),
      .halted_o     (halted_o),
      .misalign_o   (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc        = RV;
      m_valid     = 1'b0;
      m_halted    = 1'b0;
      m_mis       = 1'b0;
      m_boot_left = BOOT_N;
   endtask

   // one clock edge of the reference behaviour, using the inputs held across it
   task automatic model_edge();
      logic accept;
      accept = m_valid && pc_ready_i;
      m_mis  = 1'b0;
      if (trap_valid_i)
         m_pc = (trap_vec_i / IB) * IB;
      else if (br_valid_i) begin
         if (br_target_i % IB == 0) m_pc = br_target_i;
         else                      m_mis = 1'b1;
      end else if (accept)
         m_pc = m_pc + IB;
      if (m_boot_left > 0) begin
         m_boot_left--;
         if (m_boot_left == 0) m_valid = 1'b1;
      end else if (m_valid) begin
         if (halt_req_i) begin
            m_valid  = 1'b0;
            m_halted = 1'b1;
         end
      end else if (m_halted && !halt_req_i) begin
         m_valid  = 1'b1;
         m_halted = 1'b0;
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ".pc"},       pc_o,       m_pc);
      chk({where, ".valid"},    {31'd0, pc_valid_o}, {31'd0, m_valid});
      chk({where, ".halted"},   {31'd0, halted_o},   {31'd0, m_halted});
      chk({where, ".misalign"}, {31'd0, misalign_o}, {31'd0, m_mis});
   endtask

   task automatic step(input string where);
      @(posedge clk);
      model_edge();
      #1;
      check_all(where);
   endtask

   task automatic idle_inputs();
      br_valid_i   = 1'b0;
      trap_valid_i = 1'b0;
      br_target_i  = '0;
      trap_vec_i   = '0;
   endtask

   initial begin
      rst_n        = 1'b0;
      pc_ready_i   = 1'b1;
      halt_req_i   = 1'b0;
      idle_inputs();
      model_reset();

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("reset.pc", pc_o, RV);
      chk("reset.valid", {31'd0, pc_valid_o}, 32'd0);
      chk("reset.halted", {31'd0, halted_o}, 32'd0);
      chk("reset.misalign", {31'd0, misalign_o}, 32'd0);
      #2 rst_n = 1'b1;

      // boot delay then sequential fetch
      step("boot0");
      chk("boot0.novalid", {31'd0, pc_valid_o}, 32'd0);
      step("boot1");
      chk("first.pc", pc_o, 32'h0);
      chk("first.valid", {31'd0, pc_valid_o}, 32'd1);
      step("seq4");
      chk("seq.pc4", pc_o, 32'h4);
      step("seq8");
      chk("seq.pc8", pc_o, 32'h8);
      step("seqC");
      step("seq10");
      chk("seq.pc10", pc_o, 32'h10);

      // stall holds the unaccepted request
      pc_ready_i = 1'b0;
      repeat (3) step("stall");
      chk("stall.pc", pc_o, 32'h10);
      pc_ready_i = 1'b1;
      step("unstall");
      chk("unstall.pc", pc_o, 32'h14);

      // branch with coincident handshake
      br_valid_i  = 1'b1;
      br_target_i = 32'h200;
      step("br");
      chk("br.pc", pc_o, 32'h200);

      // misaligned branch dropped
      br_target_i = 32'h202;
      step("brmis");
      chk("brmis.pc", pc_o, 32'h200);
      chk("brmis.flag", {31'd0, misalign_o}, 32'd1);
      idle_inputs();
      step("brmis_clr");
      chk("brmis_clr.flag", {31'd0, misalign_o}, 32'd0);

      // trap beats branch, low bits forced to zero, no misalign
      trap_valid_i = 1'b1;
      trap_vec_i   = 32'h103;
      br_valid_i   = 1'b1;
      br_target_i  = 32'h201;
      step("trap");
      chk("trap.pc", pc_o, 32'h100);
      chk("trap.nomis", {31'd0, misalign_o}, 32'd0);

      // halt, redirect while halted, resume
      trap_vec_i = 32'h40;
      br_valid_i = 1'b0;
      step("to40");
      idle_inputs();
      pc_ready_i = 1'b0;
      halt_req_i = 1'b1;
      step("halt");
      chk("halt.halted", {31'd0, halted_o}, 32'd1);
      chk("halt.valid", {31'd0, pc_valid_o}, 32'd0);
      chk("halt.pc", pc_o, 32'h40);
      br_valid_i  = 1'b1;
      br_target_i = 32'h80;
      step("halt_br");
      idle_inputs();
      halt_req_i = 1'b0;
      step("resume");
      chk("resume.valid", {31'd0, pc_valid_o}, 32'd1);
      chk("resume.pc", pc_o, 32'h80);

      // halt coincident with a handshake: increment completes first
      pc_ready_i = 1'b1;
      halt_req_i = 1'b1;
      step("halt_hs");
      chk("halt_hs.pc", pc_o, 32'h84);
      halt_req_i = 1'b0;
      step("halt_hs_resume");

      // wrap-around
      trap_valid_i = 1'b1;
      trap_vec_i   = 32'hFFFF_FFFC;
      step("towrap");
      idle_inputs();
      step("wrap");
      chk("wrap.pc", pc_o, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         pc_ready_i   = ($urandom_range(3) != 0);
         trap_valid_i = ($urandom_range(15) == 0);
         trap_vec_i   = $urandom;
         br_valid_i   = ($urandom_range(7) == 0);
         br_target_i  = {$urandom_range(32'hFFFF), 14'd0, 2'($urandom_range(3))};
         if ($urandom_range(1) == 0) br_target_i[1:0] = 2'b00;
         if ($urandom_range(9) == 0) halt_req_i = ~halt_req_i;
         step("rand");
      end
      idle_inputs();
      halt_req_i = 1'b0;
      pc_ready_i = 1'b1;
      repeat (3) step("settle");

      // asynchronous reset mid-stream
      @(posedge clk);
      model_edge();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.pc", pc_o, RV);
      chk("midrst.valid", {31'd0, pc_valid_o}, 32'd0);
      chk("midrst.halted", {31'd0, halted_o}, 32'd0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      step("postrst0");
      step("postrst1");
      chk("postrst.valid", {31'd0, pc_valid_o}, 32'd1);
      step("postrst2");
      chk("postrst.pc", pc_o, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
